regwb: RTL and testbench

REGWB -- requirements
Module: regwb

---
 rtl/regwb.sv | 110 +++++++++++
 tb/tb_regwb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regwb.sv
// Register-file write-back arbiter: a single-cycle ALU result always wins,
// and queued load/multiply results share the write port round-robin.
module regwb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        mul_valid,
    output logic        mul_ready,
    input  logic [4:0]  mul_reg,
    input  logic [31:0] mul_data,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata,
    output logic        idle
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [36:0]   mem_q [DEPTH];
    logic [36:0]   mul_q [DEPTH];
    logic [PW-1:0] mem_wr, mem_rd, mul_wr, mul_rd;
    logic [CW-1:0] mem_cnt, mul_cnt;
    logic          rr;

    logic          alu_req, mem_push, mul_push, mem_pop, mul_pop, rr_flip;
    logic [36:0]   win;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic push,
                                                 input logic pop);
        case ({push, pop})
            2'b10:   return cnt + CW'(1);
            2'b01:   return cnt - CW'(1);
            default: return cnt;
        endcase
    endfunction

    // Ready depends only on registered occupancy, never on the offered valid.
    assign mem_ready = (mem_cnt < FULL);
    assign mul_ready = (mul_cnt < FULL);
    assign idle      = (mem_cnt == '0) && (mul_cnt == '0) && !regwrite;

    // Register 0 writes complete the handshake but never enter a queue.
    assign alu_req  = alu_valid && (alu_reg != 5'd0);
    assign mem_push = mem_valid && mem_ready && !rst && (mem_reg != 5'd0);
    assign mul_push = mul_valid && mul_ready && !rst && (mul_reg != 5'd0);

    // Arbitration sees only pre-edge occupancy, so a fresh push cannot win yet.
    always_comb begin
        mem_pop = 1'b0;
        mul_pop = 1'b0;
        rr_flip = 1'b0;
        win     = {alu_reg, alu_data};
        if (!alu_req) begin
            if ((mem_cnt != '0) && (mul_cnt != '0)) begin
                rr_flip = 1'b1;
                if (rr) mul_pop = 1'b1;
                else    mem_pop = 1'b1;
            end else if (mem_cnt != '0) begin
                mem_pop = 1'b1;
            end else if (mul_cnt != '0) begin
                mul_pop = 1'b1;
            end
            if (mem_pop)      win = mem_q[mem_rd];
            else if (mul_pop) win = mul_q[mul_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) mem_q[mem_wr] <= {mem_reg, mem_data};
        if (mul_push) mul_q[mul_wr] <= {mul_reg, mul_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr   <= '0;
            mem_rd   <= '0;
            mem_cnt  <= '0;
            mul_wr   <= '0;
            mul_rd   <= '0;
            mul_cnt  <= '0;
            rr       <= 1'b0;
            regwrite <= 1'b0;
            wrreg    <= '0;
            wrdata   <= '0;
        end else begin
            if (mem_push) mem_wr <= mem_wr + PW'(1);
            if (mem_pop)  mem_rd <= mem_rd + PW'(1);
            if (mul_push) mul_wr <= mul_wr + PW'(1);
            if (mul_pop)  mul_rd <= mul_rd + PW'(1);
            mem_cnt  <= next_count(mem_cnt, mem_push, mem_pop);
            mul_cnt  <= next_count(mul_cnt, mul_push, mul_pop);
            rr       <= rr ^ rr_flip;
            regwrite <= alu_req || mem_pop || mul_pop;
            if (alu_req || mem_pop || mul_pop) begin
                wrreg  <= win[36:32];
                wrdata <= win[31:0];
            end
        end
    end
endmodule

// File: tb/tb_regwb.sv
// Bench for regwb: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the write-back behaviour.
module tb_regwb;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, mul_valid;
    logic [4:0]  alu_reg, mem_reg, mul_reg;
    logic [31:0] alu_data, mem_data, mul_data;
    logic        mem_ready, mul_ready, regwrite, idle;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;

    always #5 clk = ~clk;

    regwb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_reg(mul_reg), .mul_data(mul_data),
        .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata), .idle(idle)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [36:0] memq[$];
    logic [36:0] mulq[$];
    logic        rr_m = 1'b0;
    logic        exp_rw = 1'b0;
    logic [4:0]  exp_reg = '0;
    logic [31:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        mul_valid = 0; mul_reg = 0; mul_data = 0;
    endtask

    // One clock: check pre-edge outputs, advance the model, check post-edge outputs.
    task automatic step();
        logic        mem_acc, mul_acc, have;
        logic [36:0] w;
        chk("mem_ready", mem_ready, memq.size() < DEPTH);
        chk("mul_ready", mul_ready, mulq.size() < DEPTH);
        chk("idle", idle, memq.size() == 0 && mulq.size() == 0 && !exp_rw);
        mem_acc = mem_valid && (memq.size() < DEPTH);
        mul_acc = mul_valid && (mulq.size() < DEPTH);
        if (rst) begin
            memq.delete(); mulq.delete();
            rr_m = 0; exp_rw = 0; exp_reg = 0; exp_data = 0;
        end else begin
            have = 1; w = '0;
            if (alu_valid && alu_reg != 0) w = {alu_reg, alu_data};
            else if (memq.size() > 0 && mulq.size() > 0) begin
                if (rr_m) w = mulq.pop_front();
                else      w = memq.pop_front();
                rr_m = !rr_m;
            end
            else if (memq.size() > 0) w = memq.pop_front();
            else if (mulq.size() > 0) w = mulq.pop_front();
            else have = 0;
            exp_rw = have;
            if (have) begin exp_reg = w[36:32]; exp_data = w[31:0]; end
            if (mem_acc && mem_reg != 0) memq.push_back({mem_reg, mem_data});
            if (mul_acc && mul_reg != 0) mulq.push_back({mul_reg, mul_data});
        end
        @(posedge clk); #1;
        chk("regwrite", regwrite, exp_rw);
        chk("wrreg", wrreg, exp_reg);
        chk("wrdata", wrdata, exp_data);
    endtask

    task automatic do_reset();
        quiet(); rst = 1; step(); rst = 0;
    endtask

    initial begin
        logic [4:0] seen[$];
        logic       path[$];
        logic [4:0] offers[3];
        logic       rdy;
        int         idx;

        quiet();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_regwrite", regwrite, 0);
        chk("rst_wrreg", wrreg, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_mul_ready", mul_ready, 1);
        chk("rst_idle", idle, 1);

        // ALU only
        alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_rw", regwrite, 1);
        chk("alu_reg", wrreg, 5);
        chk("alu_data", wrdata, 32'hDEADBEEF);
        quiet(); step();
        chk("alu_rw_after", regwrite, 0);

        // Contention
        mem_valid = 1; mem_reg = 3; mem_data = 32'h11;
        mul_valid = 1; mul_reg = 4; mul_data = 32'h22;
        step();
        quiet(); alu_valid = 1; alu_reg = 6; alu_data = 32'h33;
        step();
        chk("cont_first", wrreg, 6);
        quiet(); step();
        chk("cont_second", wrreg, 3);
        chk("cont_second_d", wrdata, 32'h11);
        step();
        chk("cont_third", wrreg, 4);
        chk("cont_third_d", wrdata, 32'h22);
        step();

        // Zero destination register
        mem_valid = 1; mem_reg = 0; mem_data = 32'h55;
        alu_valid = 1; alu_reg = 0; alu_data = 32'h66;
        chk("zero_ready", mem_ready, 1);
        step();
        chk("zero_rw", regwrite, 0);
        chk("zero_idle", idle, 1);
        quiet(); step();
        chk("zero_idle2", idle, 1);

        // Fairness with continuous refills
        do_reset();
        for (int i = 0; i < 14; i++) begin
            mem_valid = 1; mem_reg = 5'(8 + i % 8);  mem_data = $urandom;
            mul_valid = 1; mul_reg = 5'(16 + i % 8); mul_data = $urandom;
            step();
            if (regwrite) path.push_back(wrreg[4]);
        end
        quiet();
        chk("fair_count", (path.size() >= 8), 1);
        for (int k = 0; k < 8 && k < path.size(); k++)
            chk($sformatf("fair_%0d", k), path[k], k % 2);
        repeat (6) step();

        // Back-pressure behind continuous ALU traffic
        offers[0] = 7; offers[1] = 8; offers[2] = 9; idx = 0;
        for (int c = 0; c < 16; c++) begin
            alu_valid = (c < 6); alu_reg = 1; alu_data = c;
            mem_valid = (idx < 3); mem_reg = (idx < 3) ? offers[idx] : 5'd0; mem_data = 32'(100 + idx);
            rdy = mem_ready;
            if (c == 4) chk("full_mem_ready", mem_ready, 0);
            step();
            if (mem_valid && rdy) idx++;
            if (regwrite && wrreg != 1) seen.push_back(wrreg);
        end
        quiet();
        chk("bp_count", seen.size(), 3);
        for (int k = 0; k < 3 && k < seen.size(); k++)
            chk($sformatf("bp_order_%0d", k), seen[k], offers[k]);

        // Reset with both FIFOs full
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1; alu_reg = 2; alu_data = c;
            mem_valid = 1; mem_reg = 5'(10 + c); mem_data = c;
            mul_valid = 1; mul_reg = 5'(20 + c); mul_data = c;
            step();
        end
        chk("pre_rst_full", mem_ready, 0);
        rst = 1; step();
        rst = 0; quiet();
        chk("post_rst_rw", regwrite, 0);
        chk("post_rst_mem_ready", mem_ready, 1);
        chk("post_rst_mul_ready", mul_ready, 1);
        chk("post_rst_idle", idle, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post_rst_no_stale", regwrite, 0);
        end

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_reg   = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 4) < 3);
            mem_reg   = 5'($urandom_range(0, 31));
            mem_data  = $urandom;
            mul_valid = ($urandom_range(0, 4) < 3);
            mul_reg   = 5'($urandom_range(0, 31));
            mul_data  = $urandom;
            step();
        end
        rst = 0; quiet();
        repeat (8) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
